// File: rtl/pid_out_pkg.sv
// Shared types and helpers for the PI regulator output bank.
// Clamp works on a 64-bit signed domain; callers sign-extend.
package pid_out_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic signed [MAXW-1:0] value;
    logic                   flag;
  } clamp_res_t;

  function automatic int ch_w(input int n);
    ch_w = (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic clamp_res_t clamp(
    input logic signed [MAXW-1:0] v,
    input logic signed [MAXW-1:0] lo,
    input logic signed [MAXW-1:0] hi
  );
    clamp.value = v;
    clamp.flag  = 1'b0;
    if (v > hi) begin
      clamp.value = hi;
      clamp.flag  = 1'b1;
    end else if (v < lo) begin
      clamp.value = lo;
      clamp.flag  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation of one W-bit sample.
// Flags any input that fell outside [OUT_MIN, OUT_MAX].
module sat_clamp
  import pid_out_pkg::*;
#(
  parameter int W = 32,
  parameter logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}},
  parameter logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}}
)(
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         sat
);

  logic signed [MAXW-1:0] din_x;
  logic signed [MAXW-1:0] lo_x;
  logic signed [MAXW-1:0] hi_x;
  clamp_res_t             res;
  logic [MAXW-W:0]        top_bits;

  always_comb begin
    din_x = MAXW'($signed(din));
    lo_x  = MAXW'(OUT_MIN);
    hi_x  = MAXW'(OUT_MAX);
    res   = clamp(din_x, lo_x, hi_x);
  end

  // Result bits above W-1 are pure sign extension of a W-bit bound.
  assign top_bits = res.value[MAXW-1:W-1];
  assign dout     = res.value[W-1:0];
  assign sat      = res.flag | ~((&top_bits) | ~(|top_bits));

endmodule

// File: rtl/pid_output_bank.sv
// Double-buffered, saturating N-channel output latch for the PI core.
// Shadows fill per channel; a commit publishes them all at once.
module pid_output_bank
  import pid_out_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int W = 32,
  parameter logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}},
  parameter logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}},
  parameter bit AUTO_COMMIT = 1'b0,
  parameter int TIMEOUT = 0,
  localparam int CH_W = ch_w(N_CH)
)(
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [CH_W-1:0]   CH_SEL,
  input  logic [W-1:0]      DATA_INPUT,
  input  logic              COMMIT,
  output logic [N_CH*W-1:0] PIDOUT,
  output logic [N_CH-1:0]   WR_MASK,
  output logic [N_CH-1:0]   CLAMPED,
  output logic              UPDATED,
  output logic              FAULT
);

  logic [W-1:0]    wr_val;
  logic            wr_sat;
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] mask_q;
  logic            commit;
  logic            wd_hit;
  logic            updated_q;
  logic            fault_q;

  sat_clamp #(
    .W       (W),
    .OUT_MIN (OUT_MIN),
    .OUT_MAX (OUT_MAX)
  ) u_clamp (
    .din  (DATA_INPUT),
    .dout (wr_val),
    .sat  (wr_sat)
  );

  assign commit = COMMIT | (AUTO_COMMIT & (&mask_q));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] shadow_q;
    logic         sclamp_q;
    logic [W-1:0] live_q;
    logic         lclamp_q;

    assign wr_hit[i] = ENABLE && (CH_SEL == CH_W'(i));

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        shadow_q <= '0;
        sclamp_q <= 1'b0;
      end else if (wr_hit[i]) begin
        shadow_q <= wr_val;
        sclamp_q <= wr_sat;
      end
    end

    // Commit reads the pre-write shadow, so a same-cycle write waits.
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        live_q   <= '0;
        lclamp_q <= 1'b0;
      end else if (commit) begin
        live_q   <= shadow_q;
        lclamp_q <= sclamp_q;
      end else if (wd_hit) begin
        live_q   <= '0;
        lclamp_q <= 1'b0;
      end
    end

    assign PIDOUT[i*W +: W] = live_q;
    assign CLAMPED[i]       = lclamp_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mask_q    <= '0;
      updated_q <= 1'b0;
    end else begin
      mask_q    <= commit ? wr_hit : (mask_q | wr_hit);
      updated_q <= commit | wd_hit;
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] cnt_q;

    assign wd_hit = !commit && (cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        cnt_q   <= '0;
        fault_q <= 1'b0;
      end else if (commit) begin
        cnt_q   <= '0;
        fault_q <= 1'b0;
      end else begin
        if (cnt_q != WD_W'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
        if (wd_hit) fault_q <= 1'b1;
      end
    end
  end else begin : g_no_wd
    assign wd_hit  = 1'b0;
    assign fault_q = 1'b0;
  end

  assign WR_MASK = mask_q;
  assign UPDATED = updated_q;
  assign FAULT   = fault_q;

endmodule
